// File: rtl/button_service_master_pkg.sv
// Shared definitions for the button service master.
//   state_t   : service FSM states
//   ADDR_*    : Avalon-MM register addresses of the button PIO slave
package button_service_master_pkg;

  typedef enum logic [2:0] {
    INIT_MASK,
    IDLE,
    READ_REQ,
    READ_WAIT,
    CLEAR,
    EMIT
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/button_service_master_lowest_set_3.sv
// Combinational priority encoder for a 3-bit vector.
//   bits  : input vector
//   index : position of the lowest set bit (0 when no bit is set)
//   any   : 1 when at least one bit is set
module lowest_set_3 (
  input  logic [2:0] bits,
  output logic [1:0] index,
  output logic       any
);

  always_comb begin
    if (bits[0])      index = 2'd0;
    else if (bits[1]) index = 2'd1;
    else if (bits[2]) index = 2'd2;
    else              index = 2'd0;
  end

  assign any = |bits;

endmodule

// File: rtl/button_service_master.sv
// Avalon-MM master that services a 3-button PIO slave.
// After reset it programs the interrupt mask, then waits for irq, reads and
// clears edge_capture, and offers each captured button as a valid/ready
// event, lowest index first.
//   clk, reset          : clock and synchronous active-high reset
//   irq                 : interrupt from the PIO slave
//   address, chipselect,
//   write_n, writedata,
//   readdata            : Avalon-MM master port to the PIO slave
//   event_valid,
//   event_id,
//   event_ready         : button event stream to the consumer
module button_service_master
  import button_service_master_pkg::*;
#(
  parameter logic [2:0] IRQ_MASK = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq,
  output logic [1:0] address,
  output logic       chipselect,
  output logic       write_n,
  output logic [2:0] writedata,
  input  logic [2:0] readdata,
  output logic       event_valid,
  output logic [1:0] event_id,
  input  logic       event_ready
);

  state_t     state, state_next;
  logic [2:0] pending, pending_next;
  logic [1:0] low_index;
  logic       pending_any;

  lowest_set_3 u_lowest (
    .bits  (pending),
    .index (low_index),
    .any   (pending_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT_MASK;
      pending <= 3'b000;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no
    // path through the case statement can infer a latch.
    state_next   = state;
    pending_next = pending;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    address      = ADDR_DATA;
    writedata    = 3'b000;
    event_valid  = 1'b0;
    event_id     = 2'd0;

    unique case (state)
      INIT_MASK: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_MASK;
        writedata  = IRQ_MASK;
        state_next = IDLE;
      end
      IDLE: begin
        chipselect = 1'b1;
        address    = ADDR_DATA;
        if (irq) state_next = READ_REQ;
      end
      READ_REQ: begin
        chipselect = 1'b1;
        address    = ADDR_EDGE;
        state_next = READ_WAIT;
      end
      READ_WAIT: begin
        // The slave presents edge_capture this cycle.
        pending_next = readdata;
        state_next   = CLEAR;
      end
      CLEAR: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_EDGE;
        writedata  = 3'b000;
        state_next = pending_any ? EMIT : IDLE;
      end
      EMIT: begin
        event_valid = 1'b1;
        event_id    = low_index;
        if (event_ready) begin
          pending_next = pending & ~(3'b001 << low_index);
          if (pending_next == 3'b000) state_next = IDLE;
        end
      end
      default: state_next = INIT_MASK;
    endcase

    // Reset is synchronous, so the state register may still hold a live
    // state during the reset cycle; force the bus and event outputs quiet.
    if (reset) begin
      chipselect  = 1'b0;
      write_n     = 1'b1;
      address     = ADDR_DATA;
      writedata   = 3'b000;
      event_valid = 1'b0;
      event_id    = 2'd0;
    end
  end

endmodule

// File: tb/tb_button_service_master.sv
// Directed self-checking bench for button_service_master with a small
// behavioural model of the button PIO slave (mask, edge_capture, readdata).
module tb_button_service_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       irq;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [2:0] writedata;
  logic [2:0] readdata;
  logic       event_valid;
  logic [1:0] event_id;
  logic       event_ready;

  logic [2:0] press;
  logic       force_irq;
  logic [2:0] slv_mask;
  logic [2:0] slv_edge;
  int         mask_writes;
  int         edge_writes;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  button_service_master #(.IRQ_MASK(3'b111)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq         (irq),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .event_valid (event_valid),
    .event_id    (event_id),
    .event_ready (event_ready)
  );

  // PIO slave model: press bits are captured as edges; a write to the edge
  // register clears it; readdata is registered one cycle after the address.
  always @(posedge clk) begin
    if (reset) begin
      slv_mask <= 3'b000;
      slv_edge <= 3'b000;
      readdata <= 3'b000;
    end else begin
      if (chipselect && !write_n && address == 2'd2) slv_mask <= writedata;
      if (chipselect && !write_n && address == 2'd3) slv_edge <= 3'b000;
      else                                           slv_edge <= slv_edge | press;
      readdata <= (chipselect && write_n && address == 2'd3) ? slv_edge : 3'b000;
    end
  end

  assign irq = (|(slv_edge & slv_mask)) | force_irq;

  always @(posedge clk) begin
    if (chipselect && !write_n && address == 2'd2) mask_writes <= mask_writes + 1;
    if (chipselect && !write_n && address == 2'd3) edge_writes <= edge_writes + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic cs, input logic wn,
                           input logic [1:0] ad, input logic [2:0] wd);
    check({tag, ".cs"}, {7'd0, chipselect}, {7'd0, cs});
    check({tag, ".wn"}, {7'd0, write_n}, {7'd0, wn});
    check({tag, ".addr"}, {6'd0, address}, {6'd0, ad});
    check({tag, ".wd"}, {5'd0, writedata}, {5'd0, wd});
  endtask

  task automatic check_ev(input string tag, input logic v, input logic [1:0] id);
    check({tag, ".valid"}, {7'd0, event_valid}, {7'd0, v});
    if (v) check({tag, ".id"}, {6'd0, event_id}, {6'd0, id});
  endtask

  int wr0;

  initial begin
    reset       = 1'b1;
    event_ready = 1'b0;
    press       = 3'b000;
    force_irq   = 1'b0;
    mask_writes = 0;
    edge_writes = 0;
    repeat (3) step();

    // Reset state
    check_bus("rst", 1'b0, 1'b1, 2'd0, 3'd0);
    check_ev("rst", 1'b0, 2'd0);
    check("rst.id", {6'd0, event_id}, 8'd0);

    // Release: one mask write in the first cycle, then IDLE
    reset = 1'b0;
    #1;
    check_bus("init", 1'b1, 1'b0, 2'd2, 3'b111);
    step();
    check_bus("idle", 1'b1, 1'b1, 2'd0, 3'd0);
    step();
    check("mask_writes", mask_writes[7:0], 8'd1);
    check("slv_mask", {5'd0, slv_mask}, 8'h07);

    // Edges 101 with ready high: ids 0 then 2 back to back
    wr0 = edge_writes;
    press = 3'b101;
    step();
    press = 3'b000;
    event_ready = 1'b1;
    check("irq_seen", {7'd0, irq}, 8'd1);
    step(); check_bus("rd_req", 1'b1, 1'b1, 2'd3, 3'd0);
    step(); check_ev("rd_wait", 1'b0, 2'd0);
    step(); check_bus("clear", 1'b1, 1'b0, 2'd3, 3'd0);
    step(); check_ev("ev101_a", 1'b1, 2'd0);
    step(); check_ev("ev101_b", 1'b1, 2'd2);
    step(); check_ev("ev101_end", 1'b0, 2'd0);
    check_bus("ev101_idle", 1'b1, 1'b1, 2'd0, 3'd0);
    check("edge_writes", 8'(edge_writes - wr0), 8'd1);

    // Edge 010 with ready low for 5 cycles: id stays 1
    event_ready = 1'b0;
    press = 3'b010;
    step();
    press = 3'b000;
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      check_ev("stall", 1'b1, 2'd1);
      step();
    end
    event_ready = 1'b1;
    check_ev("stall_acc", 1'b1, 2'd1);
    step();
    check_ev("stall_done", 1'b0, 2'd0);

    // Spurious irq: clear write, no event, back to IDLE
    force_irq = 1'b1;
    step();
    force_irq = 1'b0;
    check_bus("spur_rd", 1'b1, 1'b1, 2'd3, 3'd0);
    step(); check_ev("spur_wait", 1'b0, 2'd0);
    step(); check_bus("spur_clr", 1'b1, 1'b0, 2'd3, 3'd0);
    step(); check_ev("spur_idle", 1'b0, 2'd0);
    check_bus("spur_idle", 1'b1, 1'b1, 2'd0, 3'd0);
    step(); check_ev("spur_idle2", 1'b0, 2'd0);

    // Reset during EMIT with pending 110
    event_ready = 1'b0;
    press = 3'b110;
    step();
    press = 3'b000;
    repeat (4) step();
    check_ev("pre_rst", 1'b1, 2'd1);
    reset = 1'b1;
    #1;
    check_ev("mid_rst", 1'b0, 2'd0);
    check_bus("mid_rst", 1'b0, 1'b1, 2'd0, 3'd0);
    step();
    check_ev("mid_rst2", 1'b0, 2'd0);
    reset = 1'b0;
    event_ready = 1'b1;
    #1;
    check_bus("reinit", 1'b1, 1'b0, 2'd2, 3'b111);
    step(); check_ev("reinit_idle", 1'b0, 2'd0);
    step(); check_ev("no_stale", 1'b0, 2'd0);
    check_bus("no_stale", 1'b1, 1'b1, 2'd0, 3'd0);

    // New edge during EMIT: ignored until IDLE, then a fresh event
    event_ready = 1'b0;
    press = 3'b001;
    step();
    press = 3'b000;
    repeat (4) step();
    check_ev("emit_a", 1'b1, 2'd0);
    press = 3'b100;
    step();
    press = 3'b000;
    check_ev("emit_irq", 1'b1, 2'd0);
    step();
    check_ev("emit_hold", 1'b1, 2'd0);
    event_ready = 1'b1;
    step();
    check_ev("back_idle", 1'b0, 2'd0);
    check_bus("back_idle", 1'b1, 1'b1, 2'd0, 3'd0);
    step(); check_bus("fresh_rd", 1'b1, 1'b1, 2'd3, 3'd0);
    step();
    step(); check_bus("fresh_clr", 1'b1, 1'b0, 2'd3, 3'd0);
    step(); check_ev("fresh_ev", 1'b1, 2'd2);
    step(); check_ev("fresh_end", 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
